universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 4, giving the register width in bits (minimum 2).
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port clr, input, 1 bit: synchronous, active-low reset.
REQ-004 Port parin, input, WIDTH bits: parallel load data.
REQ-005 Port sel, input, 2 bits, declared [0:1] with sel[0] as the MSB: mode select.
REQ-006 Port out, output, WIDTH bits: registered contents, driven directly from the state flops.

Function
REQ-007 The sel value SHALL be read as a 2-bit number written sel[0] sel[1].
REQ-008 sel=00 (hold): out SHALL keep its value.
REQ-009 sel=01 (shift right): out SHALL become {fill, out[WIDTH-1:1]}.
REQ-010 sel=10 (shift left): out SHALL become {out[WIDTH-2:0], fill}.
REQ-011 sel=11 (parallel load): out SHALL become parin.
REQ-012 fill SHALL be 0 unless USR_ROTATE_EN is defined (see REQ-019 and REQ-020).
REQ-013 Each operation SHALL have one-cycle latency: the result is visible on out after the rising edge at which sel and parin are sampled.
REQ-014 The block SHALL need no handshake; a new operation is accepted every cycle.
REQ-015 If sel has an X or Z bit, out SHALL hold its value, and simulation SHALL flag the condition.
REQ-016 out SHALL change only on a rising edge of clk; there SHALL be no combinational path from any input to out.

Reset
REQ-017 When clr=0 at a rising clk edge, out SHALL become all zeros, whatever the values of sel and parin.
REQ-018 Reset SHALL be synchronous; a low clr between edges SHALL have no effect until the next rising edge. When clr is released mid-sequence, the operation selected on the first edge with clr=1 SHALL apply to the zeroed value.

Configuration
REQ-019 With the macro USR_ROTATE_EN defined, shifts SHALL rotate.
- Shift right: fill = out[0].
- Shift left: fill = out[WIDTH-1].
REQ-020 Without USR_ROTATE_EN, shifts SHALL be logical, with zero fill.

Structure
REQ-021 A shared package usr_pkg SHALL hold:
- the mode constants USR_HOLD=2'b00, USR_SHR=2'b01, USR_SHL=2'b10, USR_LOAD=2'b11;
- a typedef usr_mode_t for the 2-bit mode.
REQ-022 The next-state selection SHALL be a combinational sub-module usr_next_mux, which computes the next value from the mode, the current value and parin. The top level SHALL hold only the register and the reset.

Verification
REQ-023 Reset: clr=0 for one edge with sel=11 and parin=1011 -> out=0000.
REQ-024 Load then hold: clr=1, sel=11, parin=1011 for one edge -> out=1011; then sel=00 for 3 edges -> out stays 1011.
REQ-025 Shift right: load 1011, then sel=01 for one edge -> out=0101 (logical) or 1101 (USR_ROTATE_EN).
REQ-026 Shift left: load 1011, then sel=10 for one edge -> out=0110 (logical) or 0111 (USR_ROTATE_EN).
REQ-027 Drain: load 1011, then sel=01 for 4 edges, logical build -> out=0000 after the 4th edge.
REQ-028 Reset priority: out=1011, then clr=0 with sel=10 for one edge -> 0000; then clr=1 with sel=11 and parin=0110 -> 0110 on the next edge.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register.
package usr_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t USR_HOLD = 2'b00;
    localparam usr_mode_t USR_SHR  = 2'b01;
    localparam usr_mode_t USR_SHL  = 2'b10;
    localparam usr_mode_t USR_LOAD = 2'b11;

endpackage

// File: rtl/usr_next_mux.sv
// Next-state selector for the universal shift register (combinational, no state).
// Shifts rotate when USR_ROTATE_EN is defined, otherwise they zero-fill.
module usr_next_mux
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  usr_mode_t          mode_i,
    input  logic [WIDTH-1:0]   cur_i,
    input  logic [WIDTH-1:0]   parin_i,
    output logic [WIDTH-1:0]   nxt_o
);

    logic fill_r;
    logic fill_l;

`ifdef USR_ROTATE_EN
    assign fill_r = cur_i[0];
    assign fill_l = cur_i[WIDTH-1];
`else
    assign fill_r = 1'b0;
    assign fill_l = 1'b0;
`endif

    // An unknown mode bit matches no item and falls through to hold.
    always_comb begin
        nxt_o = cur_i;
        case (mode_i)
            USR_HOLD: nxt_o = cur_i;
            USR_SHR:  nxt_o = {fill_r, cur_i[WIDTH-1:1]};
            USR_SHL:  nxt_o = {cur_i[WIDTH-2:0], fill_l};
            USR_LOAD: nxt_o = parin_i;
            default:  nxt_o = cur_i;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / load, one-cycle latency.
// Synchronous active-low clear; build with USR_ROTATE_EN for rotating shifts.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] parin,
    input  logic [0:1]       sel,
    output logic [WIDTH-1:0] out
);

    usr_mode_t        mode;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // sel is declared ascending; sel[0] is the mode MSB.
    assign mode = {sel[0], sel[1]};

    usr_next_mux #(
        .WIDTH (WIDTH)
    ) u_next_mux (
        .mode_i  (mode),
        .cur_i   (out_q),
        .parin_i (parin),
        .nxt_o   (out_d)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

    always @(posedge clk) begin
        assert (!$isunknown(sel))
            else $error("universal_shift_register: sel has X/Z, holding value");
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=4).
module tb_universal_shift_register;

    logic       clk;
    logic       clr;
    logic [3:0] parin;
    logic [0:1] sel;
    logic [3:0] out;

    int n_cmp;
    int n_bad;

    universal_shift_register #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .parin (parin),
        .sel   (sel),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp);
        n_cmp++;
        assert (out === exp)
            else begin
                n_bad++;
                $error("FAIL %s: out=%b expected=%b", tag, out, exp);
            end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic c, input logic [0:1] s, input logic [3:0] p);
        @(negedge clk);
        clr   = c;
        sel   = s;
        parin = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr   = 1'b0;
        sel   = 2'b11;
        parin = 4'b1011;

        step(1'b0, 2'b11, 4'b1011); check("reset", 4'b0000);

        step(1'b1, 2'b11, 4'b1011); check("load", 4'b1011);
        step(1'b1, 2'b00, 4'b0000); check("hold1", 4'b1011);
        step(1'b1, 2'b00, 4'b1111); check("hold2", 4'b1011);
        step(1'b1, 2'b00, 4'b0101); check("hold3", 4'b1011);

        step(1'b1, 2'b01, 4'b0000);
`ifdef USR_ROTATE_EN
        check("shr", 4'b1101);
`else
        check("shr", 4'b0101);
`endif

        step(1'b1, 2'b11, 4'b1011);
        step(1'b1, 2'b10, 4'b0000);
`ifdef USR_ROTATE_EN
        check("shl", 4'b0111);
`else
        check("shl", 4'b0110);
`endif

        step(1'b1, 2'b11, 4'b1011); check("load_drain", 4'b1011);
`ifdef USR_ROTATE_EN
        step(1'b1, 2'b01, 4'b0000); check("drain1", 4'b1101);
        step(1'b1, 2'b01, 4'b0000); check("drain2", 4'b1110);
        step(1'b1, 2'b01, 4'b0000); check("drain3", 4'b0111);
        step(1'b1, 2'b01, 4'b0000); check("drain4", 4'b1011);
`else
        step(1'b1, 2'b01, 4'b0000); check("drain1", 4'b0101);
        step(1'b1, 2'b01, 4'b0000); check("drain2", 4'b0010);
        step(1'b1, 2'b01, 4'b0000); check("drain3", 4'b0001);
        step(1'b1, 2'b01, 4'b0000); check("drain4", 4'b0000);
`endif

        step(1'b1, 2'b11, 4'b1001); check("load2", 4'b1001);
`ifdef USR_ROTATE_EN
        step(1'b1, 2'b10, 4'b0000); check("shl_a", 4'b0011);
        step(1'b1, 2'b10, 4'b0000); check("shl_b", 4'b0110);
        step(1'b1, 2'b10, 4'b0000); check("shl_c", 4'b1100);
`else
        step(1'b1, 2'b10, 4'b0000); check("shl_a", 4'b0010);
        step(1'b1, 2'b10, 4'b0000); check("shl_b", 4'b0100);
        step(1'b1, 2'b10, 4'b0000); check("shl_c", 4'b1000);
`endif

        step(1'b1, 2'b11, 4'b1011); check("prio_load", 4'b1011);
        step(1'b0, 2'b10, 4'b1111); check("prio_reset", 4'b0000);
        step(1'b1, 2'b11, 4'b0110); check("prio_release", 4'b0110);

        // clr pulsed low between edges must not clear the register.
        @(negedge clk);
        sel = 2'b00;
        #1 clr = 1'b0;
        #2 clr = 1'b1;
        @(posedge clk);
        #1;
        check("glitch_clr", 4'b0110);

        // First op after release applies to the zeroed value.
        step(1'b0, 2'b11, 4'b1111); check("reset2", 4'b0000);
        step(1'b1, 2'b01, 4'b1111); check("release_shr", 4'b0000);
        step(1'b1, 2'b11, 4'b0001); check("load3", 4'b0001);
`ifdef USR_ROTATE_EN
        step(1'b1, 2'b01, 4'b0000); check("shr_lsb", 4'b1000);
`else
        step(1'b1, 2'b01, 4'b0000); check("shr_lsb", 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
